spi_reg_bridge: RTL and testbench

- Byte-level command decoder between the SPI slave shifter and the RTC register file.
- Consumes received bytes (rx_data/rx_dv) and parses a command byte plus data bytes.
- Issues register writes, or fetches register data and loads it into the shifter's transmit buffer (tx_data/tx_wr, throttled by tx_halt).
- Burst access with address auto-increment; an inactivity timeout resynchronises framing, since SPI carries no chip-select to this block.

---
 rtl/spi_reg_bridge.sv | 131 +++++++++++++
 tb/tb_spi_reg_bridge.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// Byte-level command decoder between an SPI slave shifter and a 16-entry register file.
// Supports write and read bursts with address auto-increment and an inactivity timeout.
module spi_reg_bridge #(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_dv,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_halt,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, WR_DATA, RD_FETCH, RD_LOAD, RD_WAIT} state_t;

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  state_t        state;
  logic [3:0]    addr;
  logic [3:0]    count;
  logic [TW-1:0] timer;
  logic [7:0]    rbuf;
  logic          captured;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      tx_data   <= 8'h00;
      tx_wr     <= 1'b0;
      reg_addr  <= 4'h0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      addr      <= 4'h0;
      count     <= 4'h0;
      timer     <= '0;
      rbuf      <= 8'h00;
      captured  <= 1'b0;
    end else begin
      tx_wr  <= 1'b0;
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      err    <= 1'b0;

      if (state == IDLE) begin
        timer    <= '0;
        captured <= 1'b0;
        if (rx_dv) begin
          addr  <= rx_data[3:0];
          count <= {1'b0, rx_data[6:4]} + 4'd1;
          state <= rx_data[7] ? WR_DATA : RD_FETCH;
          busy  <= 1'b1;
        end
      end else if (rx_dv) begin
        // A received byte always restarts the inactivity timer, even on the timeout cycle.
        timer <= '0;
        case (state)
          WR_DATA: begin
            reg_we    <= 1'b1;
            reg_addr  <= addr;
            reg_wdata <= rx_data;
            addr      <= addr + 4'd1;
            count     <= count - 4'd1;
            if (count == 4'd1) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          RD_WAIT: begin
            if (count == 4'd0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= RD_FETCH;
            end
          end
          default: begin
            err   <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (timer == TIMER_MAX) begin
        timer <= '0;
        err   <= 1'b1;
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        timer <= timer + TW'(1);
        case (state)
          RD_FETCH: begin
            reg_re   <= 1'b1;
            reg_addr <= addr;
            captured <= 1'b0;
            state    <= RD_LOAD;
          end
          RD_LOAD: begin
            // While reg_re is still high the register file has not yet produced data.
            if (!reg_re) begin
              if (!captured) begin
                rbuf     <= reg_rdata;
                captured <= 1'b1;
              end
              if (!tx_halt) begin
                tx_data  <= captured ? rbuf : reg_rdata;
                tx_wr    <= 1'b1;
                addr     <= addr + 4'd1;
                count    <= count - 4'd1;
                captured <= 1'b0;
                state    <= RD_WAIT;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: a cycle-indexed expectation schedule built from the
// command rules is compared against every DUT output on every cycle.
module tb_spi_reg_bridge;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_dv;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_halt;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       err;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  // Expected events keyed by the cycle (edge count) after which they must be visible.
  logic [11:0] exp_we [int];
  logic [3:0]  exp_re [int];
  logic [7:0]  exp_tx [int];
  bit          exp_err [int];
  bit          rst_cyc [int];
  int          busy_lo [$];
  int          busy_hi [$];

  logic [11:0] wr_log [$];
  logic [7:0]  tx_log [$];
  int          err_log [$];

  spi_reg_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_dv(rx_dv),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_halt(tx_halt),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: returns 0x50 + address one cycle after the read strobe.
  always @(posedge clk) if (reg_re) reg_rdata <= 8'h50 + {4'h0, reg_addr};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  function automatic bit busy_exp(input int n);
    for (int i = 0; i < busy_lo.size(); i++)
      if (n >= busy_lo[i] && n < busy_hi[i]) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (cyc >= 1) begin
      checkOutput("reg_we", reg_we, exp_we.exists(cyc));
      if (exp_we.exists(cyc)) checkOutput("write addr/data", {reg_addr, reg_wdata}, exp_we[cyc]);
      checkOutput("reg_re", reg_re, exp_re.exists(cyc));
      if (exp_re.exists(cyc)) checkOutput("read addr", reg_addr, exp_re[cyc]);
      checkOutput("tx_wr", tx_wr, exp_tx.exists(cyc));
      if (exp_tx.exists(cyc)) checkOutput("tx_data", tx_data, exp_tx[cyc]);
      checkOutput("err", err, exp_err.exists(cyc));
      checkOutput("busy", busy, busy_exp(cyc));
      if (rst_cyc.exists(cyc)) checkOutput("reset data outputs", {tx_data, reg_addr, reg_wdata}, 0);
      if (reg_we) wr_log.push_back({reg_addr, reg_wdata});
      if (tx_wr) tx_log.push_back(tx_data);
      if (err) err_log.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  // Drives byte b so that the DUT samples it at edge edge_n.
  task automatic applyStimulus(input int edge_n, input logic [7:0] b);
    if (cyc > edge_n - 1) checkOutput("stimulus schedule", cyc, edge_n - 1);
    wait_until(edge_n - 1);
    rx_data = b;
    rx_dv   = 1'b1;
    tick();
    rx_dv   = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic set_halt_at(input int edge_n, input logic v);
    wait_until(edge_n - 1);
    tx_halt = v;
  endtask

  task automatic expect_busy(input int lo, input int hi);
    busy_lo.push_back(lo);
    busy_hi.push_back(hi);
  endtask

  int e, f, r, d1, d2, d3, t4_data;
  logic [11:0] wr_lit [12];
  logic [7:0]  tx_lit [3];

  initial begin
    rst = 1'b0; rx_dv = 1'b0; rx_data = 8'h00; tx_halt = 1'b0;
    rst_cyc[1] = 1'b1;
    rst_cyc[2] = 1'b1;
    tick();
    tick();
    rst = 1'b1;

    // Write burst: 0xA3 -> LEN 3 from address 3
    e = cyc + 2;
    expect_busy(e, e + 6);
    exp_we[e + 2] = {4'd3, 8'h11};
    exp_we[e + 4] = {4'd4, 8'h22};
    exp_we[e + 6] = {4'd5, 8'h33};
    applyStimulus(e, 8'hA3);
    applyStimulus(e + 2, 8'h11);
    applyStimulus(e + 4, 8'h22);
    applyStimulus(e + 6, 8'h33);

    // Address wrap: 0x9F -> LEN 2 from address 15
    e = cyc + 2;
    expect_busy(e, e + 2);
    exp_we[e + 1] = {4'd15, 8'hAA};
    exp_we[e + 2] = {4'd0, 8'hBB};
    applyStimulus(e, 8'h9F);
    applyStimulus(e + 1, 8'hAA);
    applyStimulus(e + 2, 8'hBB);

    // Read burst 0x21 with the shifter busy for 20 cycles, then a halt rising at the second load
    tx_halt = 1'b1;
    e  = cyc + 2;
    r  = e + 20;
    d1 = r + 8;
    d2 = d1 + 16;
    d3 = d2 + 11;
    exp_re[e + 1]  = 4'd1;
    exp_tx[r]      = 8'h51;
    exp_re[d1 + 1] = 4'd2;
    exp_tx[d1 + 8] = 8'h52;
    exp_re[d2 + 1] = 4'd3;
    exp_tx[d2 + 3] = 8'h53;
    expect_busy(e, d3);
    applyStimulus(e, 8'h21);
    set_halt_at(r, 1'b0);
    applyStimulus(d1, 8'h00);
    set_halt_at(d1 + 3, 1'b1);
    set_halt_at(d1 + 8, 1'b0);
    applyStimulus(d2, 8'hFF);
    applyStimulus(d3, 8'h00);

    // Timeout after one of two write bytes, then a normal write
    e = cyc + 2;
    t4_data = e + 2;
    exp_we[e + 2] = {4'd0, 8'h01};
    exp_err[e + 2 + TO] = 1'b1;
    expect_busy(e, e + 2 + TO);
    applyStimulus(e, 8'h90);
    applyStimulus(e + 2, 8'h01);
    f = e + 2 + TO + 3;
    exp_we[f + 1] = {4'd0, 8'h7E};
    expect_busy(f, f + 1);
    applyStimulus(f, 8'h80);
    applyStimulus(f + 1, 8'h7E);

    // Data byte arriving exactly on the timeout cycle keeps the transaction alive
    e = cyc + 2;
    exp_we[e + TO]     = {4'd1, 8'hC1};
    exp_we[e + TO + 2] = {4'd2, 8'hC2};
    expect_busy(e, e + TO + 2);
    applyStimulus(e, 8'h91);
    applyStimulus(e + TO, 8'hC1);
    applyStimulus(e + TO + 2, 8'hC2);

    // Protocol error: extra byte while the read is waiting on tx_halt
    tx_halt = 1'b1;
    e = cyc + 2;
    exp_re[e + 1]  = 4'd5;
    exp_err[e + 5] = 1'b1;
    expect_busy(e, e + 5);
    applyStimulus(e, 8'h05);
    applyStimulus(e + 5, 8'hEE);
    tx_halt = 1'b0;
    f = cyc + 4;
    exp_we[f + 1] = {4'd2, 8'h5A};
    expect_busy(f, f + 1);
    applyStimulus(f, 8'h82);
    applyStimulus(f + 1, 8'h5A);

    // Reset held for two cycles in the middle of a write burst
    e = cyc + 2;
    exp_we[e + 2] = {4'd7, 8'h44};
    expect_busy(e, e + 4);
    rst_cyc[e + 4] = 1'b1;
    rst_cyc[e + 5] = 1'b1;
    applyStimulus(e, 8'hA7);
    applyStimulus(e + 2, 8'h44);
    wait_until(e + 3);
    rst = 1'b0;
    wait_until(e + 5);
    rst = 1'b1;
    wait_until(e + 25);
    f = cyc + 2;
    exp_we[f + 1] = {4'd3, 8'h99};
    expect_busy(f, f + 1);
    applyStimulus(f, 8'h83);
    applyStimulus(f + 1, 8'h99);
    wait_until(cyc + 5);

    // Hand-computed totals that pin the expectation schedule itself
    wr_lit = '{12'h311, 12'h422, 12'h533, 12'hFAA, 12'h0BB, 12'h001,
               12'h07E, 12'h1C1, 12'h2C2, 12'h25A, 12'h744, 12'h399};
    tx_lit = '{8'h51, 8'h52, 8'h53};
    checkOutput("write count", wr_log.size(), 12);
    for (int i = 0; i < 12; i++)
      checkOutput($sformatf("write log %0d", i), (i < wr_log.size()) ? wr_log[i] : 12'hxxx, wr_lit[i]);
    checkOutput("tx count", tx_log.size(), 3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("tx log %0d", i), (i < tx_log.size()) ? tx_log[i] : 8'hxx, tx_lit[i]);
    checkOutput("err count", err_log.size(), 2);
    checkOutput("timeout latency", (err_log.size() > 0) ? err_log[0] - t4_data : -1, 64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
